// File: rtl/clock_strobe_gen.sv
// Phase-accumulator clock-enable strobes, gated by a synchronised MMCM lock/settle FSM.
// Latency: stb is one cycle after the overflowing add. No backpressure: en only pauses phase, outside RUN all is zero.
module clock_strobe_gen #(
    parameter int CHANNELS  = 2,
    parameter int ACC_W     = 16,
    parameter int LOCK_WAIT = 1024
) (
    input  logic                      clk_100m,
    input  logic                      rst_n,
    input  logic                      mmcm_locked,
    input  logic [CHANNELS*ACC_W-1:0] inc,
    input  logic                      load,
    input  logic                      en,
    input  logic                      clr_lost,
    output logic [CHANNELS-1:0]       stb,
    output logic                      locked,
    output logic                      lock_lost
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_SETTLE = 2'd2;
    localparam logic [1:0] ST_RUN    = 2'd3;

    localparam int              CNT_W       = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;
    localparam logic [CNT_W-1:0] SETTLE_INIT = CNT_W'(LOCK_WAIT - 1);

    logic                               lk_meta;
    logic                               lk_s;
    logic                               rst_rel;
    logic [1:0]                         state;
    logic [1:0]                         state_nxt;
    logic [CNT_W-1:0]                   cnt;
    logic [CNT_W-1:0]                   cnt_nxt;
    logic                               lost_evt;
    logic                               run_adv;
    logic [CHANNELS-1:0][ACC_W-1:0]     inc_q;
    logic [CHANNELS-1:0][ACC_W-1:0]     acc;
    logic [CHANNELS-1:0][ACC_W:0]       sum_w;

    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            lk_meta <= 1'b0;
            lk_s    <= 1'b0;
        end else begin
            lk_meta <= mmcm_locked;
            lk_s    <= lk_meta;
        end
    end

    // One-cycle release flag so the FSM leaves IDLE on the second edge after rst_n rises.
    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            rst_rel <= 1'b0;
        end else begin
            rst_rel <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        lost_evt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rst_rel) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (lk_s) begin
                    state_nxt = ST_SETTLE;
                    cnt_nxt   = SETTLE_INIT;
                end
            end
            ST_SETTLE: begin
                // Loss of lock beats counter expiry.
                if (!lk_s) begin
                    state_nxt = ST_WAIT;
                    lost_evt  = 1'b1;
                end else if (cnt == '0) begin
                    state_nxt = ST_RUN;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            ST_RUN: begin
                if (!lk_s) begin
                    state_nxt = ST_WAIT;
                    lost_evt  = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            lock_lost <= 1'b0;
        end else if (lost_evt) begin
            lock_lost <= 1'b1;
        end else if (clr_lost) begin
            lock_lost <= 1'b0;
        end
    end

    assign locked = (state == ST_RUN);

    // Leaving RUN this edge counts as outside RUN, so stb is already low when locked drops.
    assign run_adv = (state == ST_RUN) && lk_s;

    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            inc_q <= '0;
        end else if (load) begin
            for (int n = 0; n < CHANNELS; n++) begin
                inc_q[n] <= inc[n*ACC_W +: ACC_W];
            end
        end
    end

    always_comb begin
        for (int n = 0; n < CHANNELS; n++) begin
            sum_w[n] = {1'b0, acc[n]} + {1'b0, inc_q[n]};
        end
    end

    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            stb <= '0;
        end else begin
            for (int n = 0; n < CHANNELS; n++) begin
                if (run_adv) begin
                    if (en) begin
                        acc[n] <= sum_w[n][ACC_W-1:0];
                        stb[n] <= sum_w[n][ACC_W];
                    end else begin
                        stb[n] <= 1'b0;
                    end
                end else begin
                    acc[n] <= '0;
                    stb[n] <= 1'b0;
                end
            end
        end
    end

endmodule
